execute_stage: RTL and testbench
================================

Name: execute_stage

Overview:
- Pipeline execute stage. It is the consumer end of the 148-bit ID/EX buffer that the decode stage produces.
- Unpacks the control and operand fields, resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and runs a 4-op-class ALU with an iterative multiplier.
- Registers results into the EX/MEM buffer.
- Drives `stall` back to fetch/decode while a multiply is in progress.

Parameters:
- DATA_W, 32, datapath width.
- IDEX_SIZE, 148, width of incoming ID/EX word.
- EXMEM_SIZE, 72, width of outgoing EX/MEM word.
- MUL_STEP, 8, multiplier bits retired per BUSY cycle (BUSY lasts DATA_W/MUL_STEP cycles).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- en  in  1  global pipeline enable; low freezes FSM and EX/MEM
- idexIn  in  148  ID/EX bufferOut
- exmemWE  in  1  EX/MEM stage will write a register
- exmemRd  in  4  EX/MEM destination
- exmemResult  in  32  EX/MEM ALU result
- wbWE  in  1  write-back enable (same as register bank WE)
- wbRd  in  4  write-back destination
- wbWD  in  32  write-back data
- stall  out  1  freeze fetch/decode/ID-EX; bubble into EX/MEM
- bufferOut  out  72  EX/MEM word

Behaviour:
- Clock is `clk`; reset is `rst`, one clock domain, synchronous, active-high.
- ID/EX layout (MSB→LSB), fixed:
  - immSrc[147], branchFlag[146], memWrite[145], memToReg[144]
  - aluControl[143:140], Ra[139:136], RD1[135:104], Rb[103:100], RD2[99:68]
  - Rc[67:64], RD3[63:32], extImm[31:0]
- EX/MEM layout, fixed:
  - branchTaken[71], memWrite[70], memToReg[69], regWrite[68]
  - Rc[67:64], aluResult[63:32], storeData[31:0]
- Forwarding function fwd(R, RD):
  - exmemWE && exmemRd==R → exmemResult;
  - else wbWE && wbRd==R → wbWD;
  - else RD.
  - EX/MEM has priority. All 16 registers are real (no hardwired zero).
- Operands:
  - opA = fwd(Ra, RD1)
  - opB = immSrc ? extImm : fwd(Rb, RD2)
  - storeData = fwd(Rc, RD3)
- aluControl encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
  - 5 SHL, 6 SHR (logical), 7 SRA; shift amount opB[4:0]
  - 8 MUL (low 32 bits, unsigned shift-add)
  - 9 PASSB
  - 10–15 result 0
- ADD/SUB wrap modulo 2^32; no flags.
- branchTaken = branchFlag && (opA == storeData); aluResult = extImm when branchFlag (target).
- regWrite = !memWrite && !branchFlag.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, aluControl==8, en=1 → latch opA/opB into multiplicand/multiplier regs, clear product, cnt=0, go BUSY.
  - BUSY, en=1 → product += multiplicand×multiplier[MUL_STEP-1:0]; shift multiplicand left MUL_STEP, multiplier right MUL_STEP; cnt++; after cnt reaches DATA_W/MUL_STEP-1, go DONE.
  - DONE, en=1 → aluResult = product; go IDLE.
- stall = (IDLE && aluControl==8) || BUSY. Combinational; reset value 0.
- MUL latency: stall high 5 cycles (detect + 4 BUSY). Result captured into EX/MEM at end of DONE cycle.
- While stall=1 and en=1, EX/MEM loads all zeros (bubble: regWrite=0, memWrite=0, branchTaken=0).
- Otherwise, with en=1, EX/MEM loads the computed word every cycle. Single-cycle ops have 1-cycle latency.
- en=0: FSM state, counter, multiplier regs and EX/MEM all hold. stall still reflects current state.
- Operands are latched at detect, so changes on forwarding inputs during BUSY have no effect.
- Back-to-back MUL: DONE→IDLE, then the new MUL is detected in the next cycle; no lost instruction.
- rst (any cycle, including mid-multiply): state=IDLE, cnt=0, multiplier regs=0, bufferOut=0, stall=0 (unless idexIn holds MUL on the following cycle).

Decomposition:
- Shared package `pipeline_pkg`:
  - aluControl enum (ALU_ADD..ALU_PASSB)
  - FSM state enum
  - field-position localparams for the ID/EX and EX/MEM layouts
  - IDEX_SIZE / EXMEM_SIZE constants
- One sub-module: `iter_multiplier` (FSM + shift-add datapath, start/busy/done/product). ALU, forwarding and the EX/MEM register stay in execute_stage; the EX/MEM register reuses the existing `buffer` module.

Test Plan:
- ADD, RD1=5, RD2=7, no forwarding, en=1 → next cycle aluResult=12, regWrite=1, Rc echoed.
- ADD, Ra=3, exmemWE=1, exmemRd=3, exmemResult=100, wbWE=1, wbRd=3, wbWD=50, RD2=1 → aluResult=101 (EX/MEM priority).
- MUL, 0x0001_0003 × 0x0000_0005 → stall high exactly 5 cycles with zero bubbles in EX/MEM, then aluResult=0x0005_000F.
- immSrc=1, SRA, opA=0x8000_0000, extImm=4 → 0xF800_0000.
- Branch, opA=storeData=9, extImm=0x40 → branchTaken=1, aluResult=0x40, regWrite=0.
- rst during BUSY → next cycle bufferOut=0, stall=0 with non-MUL input; en=0 mid-BUSY holds cnt and bufferOut unchanged.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types and fixed field positions for the ID/EX and EX/MEM pipeline words.
// Holds no logic. The forwarding helper is the only function.
package pipeline_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_W      = 4;
  localparam int IDEX_SIZE  = 148;
  localparam int EXMEM_SIZE = 72;
  localparam int MUL_STEP   = 8;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SHL   = 4'd5,
    ALU_SHR   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_MUL   = 4'd8,
    ALU_PASSB = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    MUL_IDLE,
    MUL_BUSY,
    MUL_DONE
  } mul_state_e;

  // ID/EX field positions
  localparam int IDEX_IMM_SRC  = 147;
  localparam int IDEX_BRANCH   = 146;
  localparam int IDEX_MEM_WR   = 145;
  localparam int IDEX_MEM2REG  = 144;
  localparam int IDEX_ALU_HI   = 143;
  localparam int IDEX_ALU_LO   = 140;
  localparam int IDEX_RA_HI    = 139;
  localparam int IDEX_RA_LO    = 136;
  localparam int IDEX_RD1_HI   = 135;
  localparam int IDEX_RD1_LO   = 104;
  localparam int IDEX_RB_HI    = 103;
  localparam int IDEX_RB_LO    = 100;
  localparam int IDEX_RD2_HI   = 99;
  localparam int IDEX_RD2_LO   = 68;
  localparam int IDEX_RC_HI    = 67;
  localparam int IDEX_RC_LO    = 64;
  localparam int IDEX_RD3_HI   = 63;
  localparam int IDEX_RD3_LO   = 32;
  localparam int IDEX_IMM_HI   = 31;
  localparam int IDEX_IMM_LO   = 0;

  // EX/MEM field positions
  localparam int EXMEM_BR_TAKEN = 71;
  localparam int EXMEM_MEM_WR   = 70;
  localparam int EXMEM_MEM2REG  = 69;
  localparam int EXMEM_REG_WR   = 68;
  localparam int EXMEM_RC_HI    = 67;
  localparam int EXMEM_RC_LO    = 64;
  localparam int EXMEM_ALU_HI   = 63;
  localparam int EXMEM_ALU_LO   = 32;
  localparam int EXMEM_ST_HI    = 31;
  localparam int EXMEM_ST_LO    = 0;

  // The EX/MEM result is newer than the write-back result, so it wins.
  function automatic logic [DATA_W-1:0] fwd(
    input logic [REG_W-1:0]  r,
    input logic [DATA_W-1:0] rd,
    input logic              ex_we,
    input logic [REG_W-1:0]  ex_rd,
    input logic [DATA_W-1:0] ex_res,
    input logic              wb_we,
    input logic [REG_W-1:0]  wb_rd,
    input logic [DATA_W-1:0] wb_wd
  );
    if (ex_we && (ex_rd == r)) return ex_res;
    if (wb_we && (wb_rd == r)) return wb_wd;
    return rd;
  endfunction

endpackage

// File: rtl/buffer.sv
// Pipeline register that loads when en is high and holds when en is low.
// Latency is 1 cycle. A synchronous reset clears the register.
module buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] bufferIn,
  output logic [WIDTH-1:0] bufferOut
);

  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (en) data_d = bufferIn;
  end

  always_ff @(posedge clk) begin
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  end

  assign bufferOut = data_q;

endmodule

// File: rtl/iter_multiplier.sv
// Shift-add multiplier that retires STEP multiplier bits per BUSY cycle and keeps the low WIDTH bits.
// Timing is detect, then WIDTH/STEP BUSY cycles, then one DONE cycle. When en is low, everything holds.
module iter_multiplier
  import pipeline_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int STEP  = MUL_STEP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             idle,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int STEPS = WIDTH / STEP;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

  mul_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] prod_q, prod_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    if (en) begin
      case (state_q)
        MUL_IDLE: begin
          if (start) begin
            mcand_d  = op_a;
            mplier_d = op_b;
            prod_d   = '0;
            cnt_d    = '0;
            state_d  = MUL_BUSY;
          end
        end
        MUL_BUSY: begin
          // Bits shifted past WIDTH cannot reach the low word, so truncation is exact.
          prod_d   = prod_q + mcand_q * WIDTH'(mplier_q[STEP-1:0]);
          mcand_d  = mcand_q << STEP;
          mplier_d = mplier_q >> STEP;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_d = MUL_DONE;
        end
        MUL_DONE: state_d = MUL_IDLE;
        default:  state_d = MUL_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MUL_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
    end
  end

  assign idle    = (state_q == MUL_IDLE);
  assign busy    = (state_q == MUL_BUSY);
  assign done    = (state_q == MUL_DONE);
  assign product = prod_q;

endmodule

// File: rtl/execute_stage.sv
// Execute stage: forwards operands, runs the ALU and the iterative MUL, and registers the result into EX/MEM (1 cycle; MUL takes 6).
// stall holds fetch/decode during a MUL and sends bubbles into EX/MEM. When en is low, the FSM and EX/MEM hold.
module execute_stage
  import pipeline_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [IDEX_SIZE-1:0]  idexIn,
  input  logic                  exmemWE,
  input  logic [REG_W-1:0]      exmemRd,
  input  logic [DATA_W-1:0]     exmemResult,
  input  logic                  wbWE,
  input  logic [REG_W-1:0]      wbRd,
  input  logic [DATA_W-1:0]     wbWD,
  output logic                  stall,
  output logic [EXMEM_SIZE-1:0] bufferOut
);

  logic              imm_src, branch_flag, mem_write, mem_to_reg;
  logic [3:0]        alu_ctl;
  logic [REG_W-1:0]  ra, rb, rc;
  logic [DATA_W-1:0] rd1, rd2, rd3, ext_imm;

  assign imm_src     = idexIn[IDEX_IMM_SRC];
  assign branch_flag = idexIn[IDEX_BRANCH];
  assign mem_write   = idexIn[IDEX_MEM_WR];
  assign mem_to_reg  = idexIn[IDEX_MEM2REG];
  assign alu_ctl     = idexIn[IDEX_ALU_HI:IDEX_ALU_LO];
  assign ra          = idexIn[IDEX_RA_HI:IDEX_RA_LO];
  assign rd1         = idexIn[IDEX_RD1_HI:IDEX_RD1_LO];
  assign rb          = idexIn[IDEX_RB_HI:IDEX_RB_LO];
  assign rd2         = idexIn[IDEX_RD2_HI:IDEX_RD2_LO];
  assign rc          = idexIn[IDEX_RC_HI:IDEX_RC_LO];
  assign rd3         = idexIn[IDEX_RD3_HI:IDEX_RD3_LO];
  assign ext_imm     = idexIn[IDEX_IMM_HI:IDEX_IMM_LO];

  logic [DATA_W-1:0] op_a, op_b, store_data;

  assign op_a       = fwd(ra, rd1, exmemWE, exmemRd, exmemResult, wbWE, wbRd, wbWD);
  assign op_b       = imm_src ? ext_imm
                              : fwd(rb, rd2, exmemWE, exmemRd, exmemResult, wbWE, wbRd, wbWD);
  assign store_data = fwd(rc, rd3, exmemWE, exmemRd, exmemResult, wbWE, wbRd, wbWD);

  logic              mul_start, mul_idle, mul_busy, mul_done;
  logic [DATA_W-1:0] mul_product;

  assign mul_start = (alu_ctl == ALU_MUL);

  iter_multiplier #(
    .WIDTH (DATA_W),
    .STEP  (MUL_STEP)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .start   (mul_start),
    .op_a    (op_a),
    .op_b    (op_b),
    .idle    (mul_idle),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  assign stall = mul_busy || (mul_idle && mul_start);

  logic [4:0]        shamt;
  logic [DATA_W-1:0] alu_res;

  assign shamt = op_b[4:0];

  always_comb begin
    alu_res = '0;
    case (alu_ctl)
      ALU_ADD:   alu_res = op_a + op_b;
      ALU_SUB:   alu_res = op_a - op_b;
      ALU_AND:   alu_res = op_a & op_b;
      ALU_OR:    alu_res = op_a | op_b;
      ALU_XOR:   alu_res = op_a ^ op_b;
      ALU_SHL:   alu_res = op_a << shamt;
      ALU_SHR:   alu_res = op_a >> shamt;
      ALU_SRA:   alu_res = $unsigned($signed(op_a) >>> shamt);
      ALU_PASSB: alu_res = op_b;
      default:   alu_res = '0;
    endcase
  end

  logic                  branch_taken, reg_write;
  logic [DATA_W-1:0]     alu_result;
  logic [EXMEM_SIZE-1:0] exmem_word;

  assign branch_taken = branch_flag && (op_a == store_data);
  assign reg_write    = !mem_write && !branch_flag;

  always_comb begin
    alu_result = alu_res;
    if (mul_done)    alu_result = mul_product;
    if (branch_flag) alu_result = ext_imm;
  end

  always_comb begin
    exmem_word = {branch_taken, mem_write, mem_to_reg, reg_write, rc, alu_result, store_data};
    if (stall) exmem_word = '0;
  end

  buffer #(
    .WIDTH (EXMEM_SIZE)
  ) u_exmem (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .bufferIn  (exmem_word),
    .bufferOut (bufferOut)
  );

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: hand-computed vectors plus a cycle-level reference model.
// The reference model is checked on every falling edge.
module tb_execute_stage;

  logic         clk = 1'b0;
  logic         rst, en, exmemWE, wbWE;
  logic [3:0]   exmemRd, wbRd;
  logic [31:0]  exmemResult, wbWD;
  logic [147:0] idexIn;
  logic         stall;
  logic [71:0]  bufferOut;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  execute_stage dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .idexIn      (idexIn),
    .exmemWE     (exmemWE),
    .exmemRd     (exmemRd),
    .exmemResult (exmemResult),
    .wbWE        (wbWE),
    .wbRd        (wbRd),
    .wbWD        (wbWD),
    .stall       (stall),
    .bufferOut   (bufferOut)
  );

  function automatic logic [147:0] mk(logic imm, logic br, logic mw, logic mtr, logic [3:0] ctl,
                                      logic [3:0] ra, logic [31:0] rd1, logic [3:0] rb, logic [31:0] rd2,
                                      logic [3:0] rc, logic [31:0] rd3, logic [31:0] ext);
    return {imm, br, mw, mtr, ctl, ra, rd1, rb, rd2, rc, rd3, ext};
  endfunction

  function automatic logic [31:0] fwd_m(logic [3:0] r, logic [31:0] rd);
    if (exmemWE && exmemRd == r) return exmemResult;
    if (wbWE && wbRd == r) return wbWD;
    return rd;
  endfunction

  function automatic logic [71:0] model_word(logic [147:0] w, logic use_prod, logic [31:0] prod);
    logic [31:0] a, b, sd, res, ones;
    logic [4:0]  s;
    logic        bt, rw;
    ones = '1;
    a  = fwd_m(w[139:136], w[135:104]);
    b  = w[147] ? w[31:0] : fwd_m(w[103:100], w[99:68]);
    sd = fwd_m(w[67:64], w[63:32]);
    s  = b[4:0];
    case (w[143:140])
      4'd0:    res = a + b;
      4'd1:    res = a - b;
      4'd2:    res = a & b;
      4'd3:    res = a | b;
      4'd4:    res = a ^ b;
      4'd5:    res = a << s;
      4'd6:    res = a >> s;
      4'd7:    res = (a >> s) | (a[31] ? ~(ones >> s) : 32'd0);
      4'd9:    res = b;
      default: res = 32'd0;
    endcase
    if (use_prod) res = prod;
    if (w[146]) res = w[31:0];
    bt = w[146] && (a == sd);
    rw = !w[145] && !w[146];
    return {bt, w[145], w[144], rw, w[67:64], res, sd};
  endfunction

  // Phases: 0 idle, 1 multiplying, 2 result ready
  int          m_phase = 0;
  int          m_left  = 0;
  logic [31:0] m_prod  = '0;
  logic [71:0] m_buf   = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0;
      m_left  = 0;
      m_buf   = '0;
    end else if (en) begin
      if (m_phase == 0 && idexIn[143:140] == 4'd8) begin
        m_prod  = fwd_m(idexIn[139:136], idexIn[135:104]) *
                  (idexIn[147] ? idexIn[31:0] : fwd_m(idexIn[103:100], idexIn[99:68]));
        m_phase = 1;
        m_left  = 32 / 8;
        m_buf   = '0;
      end else if (m_phase == 1) begin
        m_left = m_left - 1;
        if (m_left == 0) m_phase = 2;
        m_buf = '0;
      end else if (m_phase == 2) begin
        m_buf   = model_word(idexIn, 1'b1, m_prod);
        m_phase = 0;
      end else begin
        m_buf = model_word(idexIn, 1'b0, 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    logic exp_stall;
    if (chk_on) begin
      exp_stall = (m_phase == 0 && idexIn[143:140] == 4'd8) || (m_phase == 1);
      checks++;
      if (bufferOut !== m_buf) begin
        errors++;
        $display("FAIL model_buf @%0t: got 0x%0h, expected 0x%0h", $time, bufferOut, m_buf);
      end
      checks++;
      if (stall !== exp_stall) begin
        errors++;
        $display("FAIL model_stall @%0t: got %0b, expected %0b", $time, stall, exp_stall);
      end
    end
  end

  task automatic chk(string name, logic [71:0] act, logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_mul(logic [31:0] a, logic [31:0] b, logic [31:0] exp, bit disturb);
    int n;
    idexIn = mk(0, 0, 0, 0, 4'd8, 4'd7, a, 4'd8, b, 4'd9, 32'h99, 32'd0);
    #1;
    n = 0;
    while (stall && n < 20) begin
      n++;
      if (disturb && n == 2) begin
        exmemWE = 1; exmemRd = 4'd7; exmemResult = 32'h0000_FFFF;
        wbWE = 1; wbRd = 4'd8; wbWD = 32'h1234_5678;
      end
      cyc();
      chk("mul_bubble", bufferOut, 72'd0);
    end
    chk("mul_stall_cycles", 72'(n), 72'd5);
    cyc();
    chk("mul_result", 72'(bufferOut[63:32]), 72'(exp));
    chk("mul_regwrite", 72'(bufferOut[68]), 72'd1);
    exmemWE = 0; wbWE = 0;
  endtask

  logic [3:0]  tbl_op  [10];
  logic [31:0] tbl_exp [10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tbl_op  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd9, 4'd12};
    tbl_exp = '{32'hF0F0_2137, 32'hF0F0_0331, 32'h0000_0200, 32'hF0F0_1F37, 32'hF0F0_1D37,
                32'h8780_91A0, 32'h1E1E_0246, 32'hFE1E_0246, 32'h0000_0F03, 32'h0000_0000};

    rst = 1; en = 1; exmemWE = 0; wbWE = 0; exmemRd = 0; wbRd = 0;
    exmemResult = 0; wbWD = 0;
    idexIn = mk(0, 0, 0, 0, 4'd0, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0);
    cyc(); cyc();
    chk_on = 1'b1;
    chk("reset_buf", bufferOut, 72'd0);
    chk("reset_stall", 72'(stall), 72'd0);
    rst = 0;

    idexIn = mk(0, 0, 0, 0, 4'd0, 4'd1, 32'd5, 4'd2, 32'd7, 4'd6, 32'h33, 32'd0);
    cyc();
    chk("add_result", 72'(bufferOut[63:32]), 72'd12);
    chk("add_regwrite", 72'(bufferOut[68]), 72'd1);
    chk("add_rc", 72'(bufferOut[67:64]), 72'd6);
    chk("add_store", 72'(bufferOut[31:0]), 72'h33);

    idexIn = mk(0, 0, 0, 0, 4'd0, 4'd3, 32'hDEAD, 4'd4, 32'd1, 4'd9, 32'h77, 32'd0);
    exmemWE = 1; exmemRd = 4'd3; exmemResult = 32'd100;
    wbWE = 1; wbRd = 4'd3; wbWD = 32'd50;
    cyc();
    chk("fwd_exmem_prio", 72'(bufferOut[63:32]), 72'd101);
    exmemRd = 4'd9;
    cyc();
    chk("fwd_wb_only", 72'(bufferOut[63:32]), 72'd51);
    chk("fwd_store", 72'(bufferOut[31:0]), 72'd100);
    exmemWE = 0; wbWE = 0;

    for (int i = 0; i < 10; i++) begin
      idexIn = mk(0, 0, 0, 0, tbl_op[i], 4'd1, 32'hF0F0_1234, 4'd2, 32'h0000_0F03, 4'd5, 32'd0, 32'd0);
      cyc();
      chk($sformatf("alu_op%0d", tbl_op[i]), 72'(bufferOut[63:32]), 72'(tbl_exp[i]));
    end

    idexIn = mk(1, 0, 0, 0, 4'd7, 4'd1, 32'h8000_0000, 4'd2, 32'd0, 4'd6, 32'd0, 32'd4);
    cyc();
    chk("sra_imm", 72'(bufferOut[63:32]), 72'hF800_0000);

    idexIn = mk(0, 1, 0, 0, 4'd0, 4'd1, 32'd9, 4'd2, 32'd0, 4'd3, 32'd9, 32'h40);
    cyc();
    chk("branch_taken", 72'(bufferOut[71]), 72'd1);
    chk("branch_target", 72'(bufferOut[63:32]), 72'h40);
    chk("branch_regwrite", 72'(bufferOut[68]), 72'd0);
    idexIn = mk(0, 1, 0, 0, 4'd0, 4'd1, 32'd9, 4'd2, 32'd0, 4'd3, 32'd8, 32'h40);
    cyc();
    chk("branch_not_taken", 72'(bufferOut[71]), 72'd0);

    idexIn = mk(0, 0, 1, 0, 4'd0, 4'd1, 32'd4, 4'd2, 32'd4, 4'd3, 32'hAB, 32'd0);
    cyc();
    chk("store_memwrite", 72'(bufferOut[70]), 72'd1);
    chk("store_regwrite", 72'(bufferOut[68]), 72'd0);

    do_mul(32'h0001_0003, 32'h0000_0005, 32'h0005_000F, 1'b0);
    do_mul(32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFD, 1'b0);
    do_mul(32'h0000_0100, 32'h0101_0101, 32'h0101_0100, 1'b1);

    idexIn = mk(0, 0, 0, 0, 4'd8, 4'd7, 32'd3, 4'd8, 32'd4, 4'd9, 32'd0, 32'd0);
    cyc(); cyc();
    rst = 1;
    idexIn = mk(0, 0, 0, 0, 4'd0, 4'd1, 32'd5, 4'd2, 32'd7, 4'd6, 32'd0, 32'd0);
    cyc();
    rst = 0;
    chk("rst_mid_mul_buf", bufferOut, 72'd0);
    chk("rst_mid_mul_stall", 72'(stall), 72'd0);
    cyc();
    chk("post_rst_add", 72'(bufferOut[63:32]), 72'd12);

    idexIn = mk(0, 0, 0, 0, 4'd8, 4'd7, 32'd7, 4'd8, 32'd6, 4'd9, 32'd0, 32'd0);
    cyc(); cyc();
    en = 0;
    repeat (3) begin
      cyc();
      chk("en0_stall", 72'(stall), 72'd1);
      chk("en0_buf", bufferOut, 72'd0);
    end
    en = 1;
    n = 0;
    while (stall && n < 20) begin
      n++;
      cyc();
    end
    chk("en0_remaining_busy", 72'(n), 72'd3);
    cyc();
    chk("en0_mul_result", 72'(bufferOut[63:32]), 72'd42);

    idexIn = mk(0, 0, 0, 0, 4'd0, 4'd1, 32'd5, 4'd2, 32'd7, 4'd6, 32'd0, 32'd0);
    cyc();
    en = 0;
    idexIn = mk(0, 0, 0, 0, 4'd1, 4'd1, 32'd50, 4'd2, 32'd8, 4'd6, 32'd0, 32'd0);
    cyc();
    chk("en0_hold_buf", 72'(bufferOut[63:32]), 72'd12);
    en = 1;
    cyc();
    chk("en1_resume_sub", 72'(bufferOut[63:32]), 72'd42);

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
